msrv32_store_unit: RTL and testbench

Sequential store unit for the msrv32 core: the write-side counterpart of the load path. It accepts one store per request from the execute stage and aligns the data and byte-enable mask to the addressed lane. It drives a single write request on the data-memory bus, holds it until the bus signals ready, and reports completion or error back to the pipeline. It also stalls the pipeline while a store is outstanding and aborts on bus timeout.

---
 rtl/msrv32_store_unit.sv | 151 +++++++++++++++
 tb/tb_msrv32_store_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_store_unit.sv
// Store unit for the msrv32 core: aligns store data and byte enables to the addressed lane,
// issues one registered write on the data-memory bus and reports done, bus error or timeout.
module msrv32_store_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        store_req_in,
    input  logic [1:0]  load_size_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        ahb_ready_in,
    input  logic        ahb_resp_in,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic        store_busy_out,
    output logic        store_done_out,
    output logic        store_err_out,
    output logic [1:0]  err_code_out
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  timeout_cnt;
    logic [7:0]  cnt_next;
    logic        req_next;
    logic [31:0] addr_next;
    logic [31:0] data_next;
    logic [3:0]  mask_next;
    logic        done_next;
    logic        err_next;
    logic [1:0]  code_next;
    logic [31:0] aligned_data;
    logic [3:0]  aligned_mask;
    logic        legal;

    // Lane replication and byte enables for the incoming request, plus its legality
    always_comb begin
        aligned_data = rs2_in;
        aligned_mask = 4'b1111;
        legal        = 1'b0;
        case (load_size_in)
            2'b00: begin
                aligned_data = {4{rs2_in[7:0]}};
                aligned_mask = 4'b0001 << iadder_in[1:0];
                legal        = 1'b1;
            end
            2'b01: begin
                aligned_data = {2{rs2_in[15:0]}};
                aligned_mask = iadder_in[1] ? 4'b1100 : 4'b0011;
                legal        = ~iadder_in[0];
            end
            2'b10: begin
                legal = (iadder_in[1:0] == 2'b00);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Next state and next values of every registered output
    always_comb begin
        state_next = state;
        cnt_next   = timeout_cnt;
        req_next   = ms_riscv32_mp_dmwr_req_out;
        addr_next  = ms_riscv32_mp_dmaddr_out;
        data_next  = ms_riscv32_mp_dmdata_out;
        mask_next  = ms_riscv32_mp_dmwr_mask_out;
        done_next  = 1'b0;
        err_next   = 1'b0;
        code_next  = err_code_out;
        case (state)
            S_IDLE: begin
                if (store_req_in) begin
                    if (legal) begin
                        state_next = S_WAIT;
                        cnt_next   = 8'd0;
                        req_next   = 1'b1;
                        addr_next  = {iadder_in[31:2], 2'b00};
                        data_next  = aligned_data;
                        mask_next  = aligned_mask;
                        code_next  = 2'b00;
                    end else begin
                        err_next  = 1'b1;
                        code_next = 2'b01;
                    end
                end
            end
            S_WAIT: begin
                // Ready wins over an expiring timeout on the same edge
                if (ahb_ready_in) begin
                    state_next = S_IDLE;
                    req_next   = 1'b0;
                    if (ahb_resp_in) begin
                        err_next  = 1'b1;
                        code_next = 2'b10;
                    end else begin
                        done_next = 1'b1;
                    end
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    state_next = S_IDLE;
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    code_next  = 2'b11;
                end else if (timeout_cnt != 8'hFF) begin
                    cnt_next = timeout_cnt + 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state                       <= S_IDLE;
            timeout_cnt                 <= 8'd0;
            ms_riscv32_mp_dmwr_req_out  <= 1'b0;
            ms_riscv32_mp_dmaddr_out    <= 32'd0;
            ms_riscv32_mp_dmdata_out    <= 32'd0;
            ms_riscv32_mp_dmwr_mask_out <= 4'd0;
            store_done_out              <= 1'b0;
            store_err_out               <= 1'b0;
            err_code_out                <= 2'b00;
        end else begin
            state                       <= state_next;
            timeout_cnt                 <= cnt_next;
            ms_riscv32_mp_dmwr_req_out  <= req_next;
            ms_riscv32_mp_dmaddr_out    <= addr_next;
            ms_riscv32_mp_dmdata_out    <= data_next;
            ms_riscv32_mp_dmwr_mask_out <= mask_next;
            store_done_out              <= done_next;
            store_err_out               <= err_next;
            err_code_out                <= code_next;
        end
    end

    assign store_busy_out = (state == S_WAIT);

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Self-checking bench for msrv32_store_unit: directed scenarios plus randomized stores
// checked against a lane-level reference model.
module tb_msrv32_store_unit;

    localparam int TO = 15;

    logic        clk;
    logic        rst_n;
    logic        store_req_in;
    logic [1:0]  load_size_in;
    logic [31:0] iadder_in;
    logic [31:0] rs2_in;
    logic        ahb_ready_in;
    logic        ahb_resp_in;
    logic        dmwr_req;
    logic [31:0] dmaddr;
    logic [31:0] dmdata;
    logic [3:0]  dmmask;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  code;

    int total = 0;
    int bad   = 0;

    msrv32_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .ms_riscv32_mp_clk_in       (clk),
        .ms_riscv32_mp_rst_in       (rst_n),
        .store_req_in               (store_req_in),
        .load_size_in               (load_size_in),
        .iadder_in                  (iadder_in),
        .rs2_in                     (rs2_in),
        .ahb_ready_in               (ahb_ready_in),
        .ahb_resp_in                (ahb_resp_in),
        .ms_riscv32_mp_dmwr_req_out (dmwr_req),
        .ms_riscv32_mp_dmaddr_out   (dmaddr),
        .ms_riscv32_mp_dmdata_out   (dmdata),
        .ms_riscv32_mp_dmwr_mask_out(dmmask),
        .store_busy_out             (busy),
        .store_done_out             (done),
        .store_err_out              (err),
        .err_code_out               (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a store of 2**size bytes covers lanes a .. a+n-1, every lane carries
    // byte (lane mod n) of rs2, and the access is legal only when a is a multiple of n.
    function automatic int model_nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic model_legal(input logic [1:0] size, input logic [31:0] addr);
        int a;
        a = int'(addr[1:0]);
        if (size == 2'b11) return 1'b0;
        return (a % model_nbytes(size)) == 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] m;
        int a;
        int n;
        a = int'(addr[1:0]);
        n = model_nbytes(size);
        m = 4'b0000;
        for (int i = 0; i < 4; i++) m[i] = (i >= a) && (i < a + n);
        return m;
    endfunction

    function automatic logic [31:0] model_data(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] d;
        int n;
        n = model_nbytes(size);
        d = 32'd0;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = rs2[8*(i % n) +: 8];
        return d;
    endfunction

    // Drives one request and observes the bus until one cycle after the unit returns to idle.
    // delay < 0 means ready is never raised.
    task automatic run_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] rs2,
                             input int delay, input logic resp,
                             output logic req0, output logic [31:0] oaddr, output logic [31:0] odata,
                             output logic [3:0] omask, output int busy_n, output int req_n,
                             output int done_n, output int err_n, output int pulse_c,
                             output logic [1:0] ocode, output logic hung);
        logic idle_seen;
        store_req_in = 1'b1;
        load_size_in = size;
        iadder_in    = addr;
        rs2_in       = rs2;
        ahb_ready_in = 1'b0;
        ahb_resp_in  = 1'b0;
        @(posedge clk);
        #1;
        store_req_in = 1'b0;
        iadder_in    = $urandom;
        rs2_in       = $urandom;
        load_size_in = 2'($urandom_range(0, 3));
        req0 = 1'b0; oaddr = 32'd0; odata = 32'd0; omask = 4'd0;
        busy_n = 0; req_n = 0; done_n = 0; err_n = 0; pulse_c = -1;
        hung = 1'b1; idle_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c == 0) begin
                req0 = dmwr_req; oaddr = dmaddr; odata = dmdata; omask = dmmask;
            end
            busy_n += int'(busy);
            req_n  += int'(dmwr_req);
            done_n += int'(done);
            err_n  += int'(err);
            if ((done || err) && pulse_c < 0) pulse_c = c;
            if (idle_seen) begin
                hung = 1'b0;
                break;
            end
            if (!busy) idle_seen = 1'b1;
            ahb_ready_in = (delay >= 0) && (c >= delay);
            ahb_resp_in  = ahb_ready_in ? resp : 1'($urandom_range(0, 1));
            store_req_in = idle_seen ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        ocode        = code;
        ahb_ready_in = 1'b0;
        ahb_resp_in  = 1'b0;
        store_req_in = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({dmwr_req, busy, done, err, code} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 000000", {dmwr_req, busy, done, err, code});
        end
        total++;
        if ({dmaddr, dmdata, dmmask} !== 68'h0) begin
            bad++;
            $display("[TB] FAIL reset_bus: got %h want 0", {dmaddr, dmdata, dmmask});
        end
    endtask

    task automatic test_byte_store();
        logic req0, hung;
        logic [31:0] a, d;
        logic [3:0] m;
        logic [1:0] c;
        int bn, rn, dn, en, pc;
        run_store(2'b00, 32'h0000_1002, 32'h0000_00D8, 0, 1'b0, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
        total++;
        if ({req0, a, d, m} !== {1'b1, 32'h0000_1000, 32'hD8D8_D8D8, 4'b0100}) begin
            bad++;
            $display("[TB] FAIL byte_bus: got req=%b addr=%h data=%h mask=%b want 1 00001000 d8d8d8d8 0100", req0, a, d, m);
        end
        total++;
        if (hung || dn != 1 || en != 0 || pc != 1 || c !== 2'b00) begin
            bad++;
            $display("[TB] FAIL byte_done: got hung=%b done=%0d err=%0d at=%0d code=%b want 0 1 0 1 00", hung, dn, en, pc, c);
        end
    endtask

    task automatic test_half_wait();
        logic req0, hung;
        logic [31:0] a, d;
        logic [3:0] m;
        logic [1:0] c;
        int bn, rn, dn, en, pc;
        run_store(2'b01, 32'h0000_2002, 32'h1234_C7D8, 3, 1'b0, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
        total++;
        if ({a, d, m} !== {32'h0000_2000, 32'hC7D8_C7D8, 4'b1100}) begin
            bad++;
            $display("[TB] FAIL half_bus: got addr=%h data=%h mask=%b want 00002000 c7d8c7d8 1100", a, d, m);
        end
        total++;
        if (hung || bn != 4 || dn != 1 || en != 0 || pc != 4) begin
            bad++;
            $display("[TB] FAIL half_wait: got hung=%b busy=%0d done=%0d err=%0d at=%0d want 0 4 1 0 4", hung, bn, dn, en, pc);
        end
    endtask

    task automatic test_misaligned();
        logic req0, hung;
        logic [31:0] a, d;
        logic [3:0] m;
        logic [1:0] c;
        int bn, rn, dn, en, pc;
        run_store(2'b10, 32'h0000_3001, $urandom, 0, 1'b0, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
        total++;
        if (hung || rn != 0 || bn != 0 || en != 1 || dn != 0 || pc != 0 || c !== 2'b01) begin
            bad++;
            $display("[TB] FAIL misaligned_word: got req=%0d busy=%0d err=%0d done=%0d at=%0d code=%b want 0 0 1 0 0 01", rn, bn, en, dn, pc, c);
        end
        run_store(2'b11, 32'h0000_3000, $urandom, 0, 1'b0, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
        total++;
        if (hung || rn != 0 || bn != 0 || en != 1 || dn != 0 || pc != 0 || c !== 2'b01) begin
            bad++;
            $display("[TB] FAIL reserved_size: got req=%0d busy=%0d err=%0d done=%0d at=%0d code=%b want 0 0 1 0 0 01", rn, bn, en, dn, pc, c);
        end
    endtask

    task automatic test_bus_error();
        logic req0, hung;
        logic [31:0] a, d;
        logic [3:0] m;
        logic [1:0] c;
        int bn, rn, dn, en, pc;
        run_store(2'b10, 32'h0000_4000, $urandom, 0, 1'b1, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
        total++;
        if (hung || en != 1 || dn != 0 || rn != 1 || pc != 1 || c !== 2'b10 || dmwr_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bus_error: got err=%0d done=%0d req=%0d at=%0d code=%b want 1 0 1 1 10", en, dn, rn, pc, c);
        end
    endtask

    task automatic test_timeout();
        logic req0, hung;
        logic [31:0] a, d;
        logic [3:0] m;
        logic [1:0] c;
        int bn, rn, dn, en, pc;
        run_store(2'b10, 32'h0000_5000, $urandom, -1, 1'b0, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
        total++;
        if (hung || rn != TO || en != 1 || dn != 0 || pc != TO || c !== 2'b11) begin
            bad++;
            $display("[TB] FAIL timeout: got req=%0d err=%0d done=%0d at=%0d code=%b want %0d 1 0 %0d 11", rn, en, dn, pc, c, TO, TO);
        end
    endtask

    task automatic test_back_to_back();
        int req_cycles;
        logic [31:0] rs2;
        logic found;
        store_req_in = 1'b1;
        load_size_in = 2'b10;
        iadder_in    = 32'h0000_7000;
        rs2_in       = $urandom;
        @(posedge clk);
        #1;
        store_req_in = 1'b0;
        req_cycles = 0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) begin
                found = 1'b1;
                break;
            end
            req_cycles += int'(dmwr_req);
            @(posedge clk);
            #1;
        end
        total++;
        if (!found || req_cycles != TO || err !== 1'b1 || code !== 2'b11) begin
            bad++;
            $display("[TB] FAIL b2b_abort: got found=%b req=%0d err=%b code=%b want 1 %0d 1 11", found, req_cycles, err, code, TO);
        end
        rs2 = $urandom;
        store_req_in = 1'b1;
        load_size_in = 2'b00;
        iadder_in    = 32'h0000_7001;
        rs2_in       = rs2;
        @(posedge clk);
        #1;
        store_req_in = 1'b0;
        total++;
        if ({busy, dmwr_req, code, dmmask, dmdata} !== {1'b1, 1'b1, 2'b00, 4'b0010, model_data(2'b00, rs2)}) begin
            bad++;
            $display("[TB] FAIL b2b_accept: got busy=%b req=%b code=%b mask=%b data=%h want 1 1 00 0010 %h",
                     busy, dmwr_req, code, dmmask, dmdata, model_data(2'b00, rs2));
        end
        ahb_ready_in = 1'b1;
        @(posedge clk);
        #1;
        ahb_ready_in = 1'b0;
        total++;
        if ({busy, dmwr_req, done, err} !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL b2b_done: got %b want 0010", {busy, dmwr_req, done, err});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_store();
        logic req0, hung;
        logic [31:0] a, d, rs2;
        logic [3:0] m;
        logic [1:0] c;
        int bn, rn, dn, en, pc;
        store_req_in = 1'b1;
        load_size_in = 2'b10;
        iadder_in    = 32'h0000_6000;
        rs2_in       = $urandom;
        @(posedge clk);
        #1;
        store_req_in = 1'b0;
        @(posedge clk);
        #1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({dmwr_req, busy, done, err, code, dmaddr, dmdata, dmmask} !== 74'h0) begin
            bad++;
            $display("[TB] FAIL reset_async: got req=%b busy=%b done=%b err=%b code=%b want all 0", dmwr_req, busy, done, err, code);
        end
        @(posedge clk);
        #1;
        total++;
        if ({done, err, busy} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_nopulse: got %b want 000", {done, err, busy});
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rs2 = $urandom;
        run_store(2'b00, 32'h0000_0000, rs2, 1, 1'b0, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
        total++;
        if (hung || {req0, a, d, m} !== {1'b1, 32'h0, model_data(2'b00, rs2), 4'b0001} || dn != 1 || en != 0 || pc != 2) begin
            bad++;
            $display("[TB] FAIL reset_recover: got req=%b addr=%h data=%h mask=%b done=%0d err=%0d at=%0d", req0, a, d, m, dn, en, pc);
        end
    endtask

    task automatic test_random();
        logic req0, hung, resp, lg;
        logic [31:0] a, d, addr, rs2;
        logic [3:0] m;
        logic [1:0] c, size, want_code;
        int bn, rn, dn, en, pc, delay, edges;
        for (int it = 0; it < 40; it++) begin
            size  = 2'($urandom_range(0, 3));
            addr  = $urandom;
            rs2   = $urandom;
            delay = int'($urandom_range(0, 18));
            resp  = ($urandom_range(0, 4) == 0);
            run_store(size, addr, rs2, delay, resp, req0, a, d, m, bn, rn, dn, en, pc, c, hung);
            lg = model_legal(size, addr);
            total++;
            if (!lg) begin
                if (hung || rn != 0 || bn != 0 || en != 1 || dn != 0 || pc != 0 || c !== 2'b01) begin
                    bad++;
                    $display("[TB] FAIL rand_illegal[%0d]: got req=%0d busy=%0d err=%0d done=%0d at=%0d code=%b", it, rn, bn, en, dn, pc, c);
                end
            end else begin
                // Outcome decided by whichever comes first: ready, or the timeout window closing
                edges = (delay < TO) ? delay + 1 : TO;
                want_code = (delay >= TO) ? 2'b11 : (resp ? 2'b10 : 2'b00);
                if (hung || req0 !== 1'b1 || a !== {addr[31:2], 2'b00} || d !== model_data(size, rs2) ||
                    m !== model_mask(size, addr) || bn != edges || rn != edges || pc != edges ||
                    dn != int'(want_code == 2'b00) || en != int'(want_code != 2'b00) || c !== want_code) begin
                    bad++;
                    $display("[TB] FAIL rand_store[%0d]: got addr=%h data=%h mask=%b busy=%0d done=%0d err=%0d code=%b want %h %h %b %0d code=%b",
                             it, a, d, m, bn, dn, en, c, {addr[31:2], 2'b00}, model_data(size, rs2),
                             model_mask(size, addr), edges, want_code);
                end
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        store_req_in = 1'b0;
        load_size_in = 2'b00;
        iadder_in    = 32'd0;
        rs2_in       = 32'd0;
        ahb_ready_in = 1'b0;
        ahb_resp_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_byte_store();
        test_half_wait();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
